// File: rtl/set_min_delay_pipe_if.sv
// Streaming bus for set_min_delay_pipe: inbound word port1 and outbound word port2, each with valid/ready.
// A word moves only on a rising edge where valid and ready are both high; the sender must hold the word and valid until then.
interface set_min_delay_pipe_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] port1;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] port2;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output port1, in_valid, out_ready,
      input  in_ready, port2, out_valid
   );

   modport slave (
      input  port1, in_valid, out_ready,
      output in_ready, port2, out_valid
   );
endinterface

// File: rtl/set_min_delay_pipe.sv
// Launch register u1 feeding a 2-entry capture buffer u2 through nets net1/net1_vld/net2 (hold-path target).
// Optional transfer counter compiled in by SET_MIN_DELAY_PIPE_CNT_EN; otherwise xfer_cnt is tied to 0.
module set_min_delay_pipe_launch #(
   parameter int WIDTH = 8
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic [WIDTH-1:0] port1,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             net2,
   output logic [WIDTH-1:0] net1,
   output logic             net1_vld
);
   assign in_ready = !net1_vld || net2;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         net1     <= '0;
         net1_vld <= 1'b0;
      end else if (in_valid && in_ready) begin
         net1     <= port1;
         net1_vld <= 1'b1;
      end else if (net2) begin
         net1_vld <= 1'b0;
      end
   end
endmodule

module set_min_delay_pipe_capture #(
   parameter int WIDTH = 8
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic [WIDTH-1:0] net1,
   input  logic             net1_vld,
   output logic             net2,
   output logic [WIDTH-1:0] port2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       state_dbg
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             push;
   logic             pop;
   logic             load_head;
   logic             load_tail;
   logic             head_from_tail;

   // Ready and valid come straight from the state register, never from inputs.
   assign net2      = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign port2     = head;
   assign state_dbg = state;
   assign push      = net1_vld && net2;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_next;
   end

   always_comb begin
      state_next     = state;
      load_head      = 1'b0;
      load_tail      = 1'b0;
      head_from_tail = 1'b0;
      case (state)
         EMPTY: begin
            if (push) begin
               state_next = ONE;
               load_head  = 1'b1;
            end
         end
         ONE: begin
            if (push && pop) begin
               load_head = 1'b1;
            end else if (push) begin
               state_next = TWO;
               load_tail  = 1'b1;
            end else if (pop) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_next     = ONE;
               head_from_tail = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (load_head)           head <= net1;
         else if (head_from_tail) head <= tail;
         if (load_tail)           tail <= net1;
      end
   end
endmodule

module set_min_delay_pipe #(
   parameter int WIDTH = 8
) (
   input  logic                 clk1,
   input  logic                 rst,
   set_min_delay_pipe_if.slave  bus,
   output logic [7:0]           xfer_cnt,
   output logic [1:0]           state_dbg
);
   logic [WIDTH-1:0] net1;
   logic             net1_vld;
   logic             net2;
   logic             in_ready;
   logic [WIDTH-1:0] port2;
   logic             out_valid;

   assign bus.in_ready  = in_ready;
   assign bus.port2     = port2;
   assign bus.out_valid = out_valid;

   set_min_delay_pipe_launch #(.WIDTH(WIDTH)) u1 (
      .clk1     (clk1),
      .rst      (rst),
      .port1    (bus.port1),
      .in_valid (bus.in_valid),
      .in_ready (in_ready),
      .net2     (net2),
      .net1     (net1),
      .net1_vld (net1_vld)
   );

   set_min_delay_pipe_capture #(.WIDTH(WIDTH)) u2 (
      .clk1      (clk1),
      .rst       (rst),
      .net1      (net1),
      .net1_vld  (net1_vld),
      .net2      (net2),
      .port2     (port2),
      .out_valid (out_valid),
      .out_ready (bus.out_ready),
      .state_dbg (state_dbg)
   );

`ifdef SET_MIN_DELAY_PIPE_CNT_EN
   logic pop;
   assign pop = out_valid && bus.out_ready;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst)      xfer_cnt <= 8'd0;
      else if (pop) xfer_cnt <= xfer_cnt + 8'd1;
   end
`else
   assign xfer_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_set_min_delay_pipe.sv
// Directed bench for set_min_delay_pipe: hand-computed checks plus an in-order scoreboard of accepted words.
module tb_set_min_delay_pipe;
   localparam int WIDTH = 8;

   logic       clk1;
   logic       rst;
   logic [7:0] xfer_cnt;
   logic [1:0] state_dbg;

   set_min_delay_pipe_if #(.WIDTH(WIDTH)) bus ();

   set_min_delay_pipe #(.WIDTH(WIDTH)) dut (
      .clk1      (clk1),
      .rst       (rst),
      .bus       (bus),
      .xfer_cnt  (xfer_cnt),
      .state_dbg (state_dbg)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   logic [7:0] exp_cnt = 8'd0;
   logic [WIDTH-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample the handshakes, update the scoreboard, then advance one edge and settle.
   task automatic cycle();
      logic             acc;
      logic             pop;
      logic [WIDTH-1:0] d;
      acc = bus.in_valid && bus.in_ready;
      pop = bus.out_valid && bus.out_ready;
      d   = bus.port2;
      if (pop) begin
         pops++;
`ifdef SET_MIN_DELAY_PIPE_CNT_EN
         exp_cnt = exp_cnt + 8'd1;
`endif
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_extra_word observed %0h expected none", d);
         end else begin
            chk("sb_order", 32'(d), 32'(exp_q.pop_front()));
         end
      end
      if (acc) exp_q.push_back(bus.port1);
      @(posedge clk1);
      #1;
   endtask

   task automatic push_three(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.port1 = a; cycle();
      bus.port1 = b; cycle();
      bus.port1 = c; cycle();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.port1     = '0;
      repeat (2) @(posedge clk1);
      #1;
      exp_q.delete();
      exp_cnt = 8'd0;
      pops    = 0;
      #2 rst = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      logic       acc;

      // Reset state
      do_reset();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_port2", 32'(bus.port2), 32'd0);
      chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_state", 32'(state_dbg), 32'd0);

      // Single word latency
      bus.out_ready = 1'b1;
      bus.port1     = 8'h5A;
      bus.in_valid  = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
      cycle();
      chk("lat_valid", 32'(bus.out_valid), 32'd1);
      chk("lat_data", 32'(bus.port2), 32'h5A);
      cycle();
      chk("lat_drained", 32'(bus.out_valid), 32'd0);
`ifdef SET_MIN_DELAY_PIPE_CNT_EN
      chk("lat_cnt", 32'(xfer_cnt), 32'd1);
`else
      chk("lat_cnt", 32'(xfer_cnt), 32'd0);
`endif

      // Back-to-back stream, one word per cycle
      for (int i = 1; i <= 16; i++) begin
         bus.port1    = 8'(i);
         bus.in_valid = 1'b1;
         chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
         cycle();
         if (i >= 2) begin
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            chk("stream_data", 32'(bus.port2), 32'(i - 1));
         end
      end
      bus.in_valid = 1'b0;
      cycle();
      chk("stream_last", 32'(bus.port2), 32'h10);
      cycle();
      chk("stream_empty", 32'(bus.out_valid), 32'd0);

      // Fill under backpressure, then drain
      push_three(8'hA1, 8'hA2, 8'hA3);
      chk("fill_state", 32'(state_dbg), 32'd2);
      chk("fill_net1", 32'(dut.net1), 32'hA3);
      chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
      chk("fill_head", 32'(bus.port2), 32'hA1);
      cycle();
      chk("stall_head", 32'(bus.port2), 32'hA1);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      cycle();
      chk("drain_a2", 32'(bus.port2), 32'hA2);
      chk("drain_state_one", 32'(state_dbg), 32'd1);
      cycle();
      chk("drain_a3", 32'(bus.port2), 32'hA3);
      cycle();
      chk("drain_empty", 32'(bus.out_valid), 32'd0);

      // Alternating out_ready with continuous offered input
      d = 8'h30;
      for (int i = 0; i < 20; i++) begin
         bus.port1     = d;
         bus.in_valid  = 1'b1;
         bus.out_ready = (i % 2 == 0);
         acc = bus.in_ready;
         cycle();
         if (acc) d = d + 8'd1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (6) cycle();
      chk("alt_drained", 32'(exp_q.size()), 32'd0);
      chk("alt_empty", 32'(bus.out_valid), 32'd0);
      chk("alt_cnt", 32'(xfer_cnt), 32'(exp_cnt));

      // Asynchronous reset with words buffered
      push_three(8'hB1, 8'hB2, 8'hB3);
      chk("pre_rst_state", 32'(state_dbg), 32'd2);
      #3 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_port2", 32'(bus.port2), 32'd0);
      chk("arst_cnt", 32'(xfer_cnt), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("arst_net1", 32'(dut.net1), 32'd0);
      exp_q.delete();
      exp_cnt = 8'd0;
      #2 rst = 1'b0;
      bus.out_ready = 1'b1;
      bus.port1     = 8'hC5;
      bus.in_valid  = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      chk("post_rst_not_yet", 32'(bus.out_valid), 32'd0);
      cycle();
      chk("post_rst_data", 32'(bus.port2), 32'hC5);
      cycle();
      chk("post_rst_empty", 32'(bus.out_valid), 32'd0);

      // 257 pops from a fresh reset: counter wraps to 1
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 257; i++) begin
         bus.port1    = 8'(i * 7 + 3);
         bus.in_valid = 1'b1;
         cycle();
      end
      bus.in_valid = 1'b0;
      repeat (3) cycle();
      chk("wrap_pops", 32'(pops), 32'd257);
`ifdef SET_MIN_DELAY_PIPE_CNT_EN
      chk("wrap_cnt", 32'(xfer_cnt), 32'd1);
`else
      chk("wrap_cnt", 32'(xfer_cnt), 32'd0);
`endif
      chk("final_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
